wdt_window_multi: RTL and testbench
===================================

// Module: wdt_window_multi
// PURPOSE
//  Multi-channel windowed watchdog. Parametrised successor to the single-channel data-stall WDT.
//  Each channel watches its own data bus. Any change of the word versus the previous cycle is a "kick".
//  - No kick for TIMEOUT cycles -> interrupt. No kick for a further BITE_DLY cycles -> bite (reset request).
//  - A kick arriving sooner than WIN_MIN cycles after the previous one -> early-kick error.
//  Sits beside the datapath it supervises and feeds the system interrupt/reset controller.
// PARAMETERS
//  DATA_WIDTH  32  width of each monitored channel word
//  NUM_CH      4   number of independent channels
//  TIMEOUT     32  kick-free cycles until irq; must be > WIN_MIN
//  WIN_MIN     4   minimum legal kick spacing in cycles; >= 1
//  BITE_DLY    16  additional kick-free cycles after irq until bite; >= 1
//  CNT_WIDTH   localparam = $clog2(TIMEOUT+BITE_DLY+1)
// PORTS
//  clk            in   1                  clock, all logic on rising edge
//  rst            in   1                  synchronous reset, active-high
//  en             in   NUM_CH             per-channel enable
//  data_in        in   NUM_CH*DATA_WIDTH  channel c = data_in[c*DATA_WIDTH +: DATA_WIDTH]
//  irq_clr        in   NUM_CH             1-cycle pulse; clears sticky irq/early_err of channel c
//  irq            out  NUM_CH             sticky timeout interrupt per channel
//  early_err      out  NUM_CH             sticky early-kick error per channel
//  bite           out  1                  sticky OR of all bitten channels; cleared only by rst
//  interrupt_top  out  1                  |irq | |early_err (combinational from regs)
// BEHAVIOUR
//  Reset: rst=1 at an edge -> every channel IDLE, cnt=0, prev_q=0; irq, early_err, bite = 0.
//   Reset takes priority over everything and aborts any state.
//  Per-channel registers: prev_q (sampled data_in every cycle, all states), cnt, state.
//  kick = (data_in_c != prev_q), evaluated only in RUN/EXPIRED.
//  States, per channel:
//  - IDLE: cnt=0; no kick evaluation.
//     en=1 -> RUN, cnt=0. The first RUN cycle compares against the word sampled while IDLE.
//  - RUN, when no kick: cnt<=cnt+1.
//     If cnt+1==TIMEOUT -> EXPIRED and set irq. irq is visible exactly TIMEOUT edges after RUN entry.
//  - RUN, when kick: cnt<=0.
//     If cnt+1 < WIN_MIN, also set early_err. Measured as elapsed cycles since the last kick or RUN entry.
//  - EXPIRED, when no kick: cnt<=cnt+1.
//     If cnt+1==TIMEOUT+BITE_DLY -> BITTEN and set bite.
//  - EXPIRED, when kick: -> RUN, cnt<=0. irq stays set (sticky). No early check in EXPIRED.
//  - BITTEN: terminal; cnt holds; kicks ignored. Left only via rst or en=0.
//  en=0 in RUN/EXPIRED/BITTEN -> IDLE, cnt=0 next edge; sticky flags retained.
//  Sticky clear: irq_clr[c]=1 clears irq[c] and early_err[c] next edge.
//   A set condition on the same edge wins (flag stays 1).
//  bite is never cleared by irq_clr or en; rst only.
//  cnt is unsigned CNT_WIDTH and never exceeds TIMEOUT+BITE_DLY (no wrap).
//  Channels are fully independent; simultaneous events on different channels do not interact.
//  Latency: kick/expiry -> flag = 1 edge; interrupt_top follows flags combinationally.
// TESTING (bench: NUM_CH=2, TIMEOUT=32, WIN_MIN=4, BITE_DLY=16)
//  1. rst 2 cycles; en=2'b01; ch0 data constant 'hA
//     -> irq[0]=1 exactly 32 edges after RUN entry; bite=1 at 48; ch1 outputs stay 0.
//  2. ch0 data toggles 'hA/'hC every 10 cycles for 300 cycles -> irq, early_err, bite remain 0.
//  3. ch0 kicks 2 cycles apart ('hA->'hC->'hE)
//     -> early_err[0]=1 next edge, interrupt_top=1; irq_clr[0] pulse -> early_err[0]=0.
//  4. Let ch0 expire; kick at cnt=40
//     -> back to RUN, irq[0] stays 1, bite never asserts; irq_clr then clears irq[0].
//  5. irq_clr[0] on the same edge as expiry -> irq[0]=1 afterwards (set wins).
//  6. rst=1 mid-EXPIRED -> all outputs 0 next edge.
//     en[0]=0 mid-RUN -> cnt=0, sticky flags unchanged, no irq while disabled.

Source files
------------

// File: rtl/wdt_window_multi.sv
// Multi-channel windowed watchdog.
// Each channel treats any change of its data word against the previous cycle as a kick.
// - A channel that sees no kick for TIMEOUT cycles raises irq.
// - A further BITE_DLY kick-free cycles makes it bite.
// - A kick that arrives too soon after the previous one raises early_err.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | channel disabled, cnt held at 0, no kick evaluation
// RUN      | counting kick-free cycles, early-kick window checked
// EXPIRED  | irq raised, counting toward bite, kick returns to RUN
// BITTEN   | terminal, cnt frozen, kicks ignored until rst or en=0
module wdt_window_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int TIMEOUT    = 32,
  parameter int WIN_MIN    = 4,
  parameter int BITE_DLY   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            irq_clr,
  output logic [NUM_CH-1:0]            irq,
  output logic [NUM_CH-1:0]            early_err,
  output logic                         bite,
  output logic                         interrupt_top
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT + BITE_DLY + 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] BITE_AT_C = CNT_WIDTH'(TIMEOUT + BITE_DLY);
  localparam logic [CNT_WIDTH-1:0] WIN_MIN_C = CNT_WIDTH'(WIN_MIN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2,
    ST_BITTEN  = 2'd3
  } state_t;

  logic [NUM_CH-1:0] bite_set;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0]  prev_q, word;
    logic                   kick, set_irq, set_err, set_bite;
    logic                   irq_q, err_q;

    assign word    = data_in[c*DATA_WIDTH +: DATA_WIDTH];
    assign kick    = (word != prev_q);
    assign cnt_inc = cnt_q + 1'b1;

    // Next-state and flag-set decode; disable wins over any kick or expiry.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      set_irq  = 1'b0;
      set_err  = 1'b0;
      set_bite = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (en[c]) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!en[c]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (kick) begin
            cnt_d = '0;
            if (cnt_inc < WIN_MIN_C) set_err = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == TIMEOUT_C) begin
              state_d = ST_EXPIRED;
              set_irq = 1'b1;
            end
          end
        end
        ST_EXPIRED: begin
          if (!en[c]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (kick) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == BITE_AT_C) begin
              state_d  = ST_BITTEN;
              set_bite = 1'b1;
            end
          end
        end
        ST_BITTEN: begin
          if (!en[c]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Channel registers; a set condition beats a same-edge clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        prev_q  <= '0;
        irq_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        prev_q  <= word;
        irq_q   <= set_irq | (irq_q & ~irq_clr[c]);
        err_q   <= set_err | (err_q & ~irq_clr[c]);
      end
    end

    assign irq[c]       = irq_q;
    assign early_err[c] = err_q;
    assign bite_set[c]  = set_bite;
  end

  // Global bite request, only rst releases it.
  always_ff @(posedge clk) begin
    if (rst) bite <= 1'b0;
    else     bite <= bite | (|bite_set);
  end

  assign interrupt_top = (|irq) | (|early_err);

endmodule

// File: tb/tb_wdt_window_multi.sv
// Bench for wdt_window_multi: directed scenarios followed by random traffic,
// all cycles compared against an age-based behavioural model.
module tb_wdt_window_multi;
  localparam int DW = 8, NC = 2, TO = 32, WM = 4, BD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] en = '0;
  logic [NC-1:0] irq_clr = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic [NC*DW-1:0] data_in;
  logic [NC-1:0] irq, early_err;
  logic          bite, interrupt_top;

  assign data_in = {d1, d0};

  wdt_window_multi #(.DATA_WIDTH(DW), .NUM_CH(NC), .TIMEOUT(TO), .WIN_MIN(WM), .BITE_DLY(BD)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .irq_clr(irq_clr),
    .irq(irq), .early_err(early_err), .bite(bite), .interrupt_top(interrupt_top)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: per channel, whether it is watching, cycles since the last kick or
  // start of watching, whether the timeout already passed, and whether it bit.
  bit          m_on[NC], m_late[NC], m_dead[NC];
  int          m_age[NC];
  logic [DW-1:0] m_prev[NC];
  logic [NC-1:0] m_irq = '0, m_err = '0;
  logic        m_bite = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] w;
    bit kick, s_irq, s_err;
    for (int c = 0; c < NC; c++) begin
      w = (c == 0) ? d0 : d1;
      if (rst) begin
        m_on[c] = 0; m_late[c] = 0; m_dead[c] = 0; m_age[c] = 0;
        m_prev[c] = '0; m_irq[c] = 0; m_err[c] = 0;
        continue;
      end
      kick  = (w != m_prev[c]);
      s_irq = 0; s_err = 0;
      if (!m_on[c]) begin
        if (en[c]) begin m_on[c] = 1; m_age[c] = 0; m_late[c] = 0; m_dead[c] = 0; end
      end else if (!en[c]) begin
        m_on[c] = 0; m_age[c] = 0;
      end else if (m_dead[c]) begin
        // frozen
      end else if (kick) begin
        if (!m_late[c] && (m_age[c] + 1 < WM)) s_err = 1;
        m_age[c] = 0; m_late[c] = 0;
      end else begin
        m_age[c]++;
        if (!m_late[c] && m_age[c] == TO) begin m_late[c] = 1; s_irq = 1; end
        if (m_late[c] && m_age[c] == TO + BD) begin m_dead[c] = 1; m_bite = 1; end
      end
      m_irq[c] = s_irq | (m_irq[c] & ~irq_clr[c]);
      m_err[c] = s_err | (m_err[c] & ~irq_clr[c]);
      m_prev[c] = w;
    end
    if (rst) m_bite = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("irq", 32'(irq), 32'(m_irq));
    chk("early_err", 32'(early_err), 32'(m_err));
    chk("bite", 32'(bite), 32'(m_bite));
    chk("interrupt_top", 32'(interrupt_top), 32'((|m_irq) | (|m_err)));
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  initial begin
    // 1: constant data -> irq at 32 edges, bite at 48
    d0 = 8'hA; d1 = 8'h3c; do_reset();
    en = 2'b01; step();
    repeat (31) step();
    chk("t1_irq_at31", 32'(irq[0]), 0);
    step();
    chk("t1_irq_at32", 32'(irq[0]), 1);
    repeat (15) step();
    chk("t1_bite_at47", 32'(bite), 0);
    step();
    chk("t1_bite_at48", 32'(bite), 1);
    chk("t1_ch1_quiet", 32'({irq[1], early_err[1]}), 0);

    // 2: regular kicks every 10 cycles keep everything quiet
    d0 = 8'hA; do_reset(); en = 2'b01; step();
    for (int i = 0; i < 300; i++) begin
      if (i % 10 == 9) d0 = (d0 == 8'hA) ? 8'hC : 8'hA;
      step();
    end
    chk("t2_quiet", 32'({irq[0], early_err[0], bite}), 0);

    // 3: two kicks 2 cycles apart -> early error
    repeat (10) step();
    d0 = 8'hA; repeat (10) step();
    d0 = 8'hC; step(); step();
    d0 = 8'hE; step();
    chk("t3_early", 32'(early_err[0]), 1);
    chk("t3_top", 32'(interrupt_top), 1);
    irq_clr = 2'b01; step(); irq_clr = 2'b00;
    chk("t3_cleared", 32'(early_err[0]), 0);

    // 4: kick at cnt=40 rescues from bite, irq stays sticky
    d0 = 8'hA; do_reset(); en = 2'b01; step();
    repeat (40) step();
    chk("t4_expired", 32'(irq[0]), 1);
    d0 = 8'hC; step();
    chk("t4_irq_sticky", 32'(irq[0]), 1);
    repeat (20) step();
    chk("t4_no_bite", 32'(bite), 0);
    irq_clr = 2'b01; step(); irq_clr = 2'b00;
    chk("t4_irq_clr", 32'(irq[0]), 0);

    // 5: clear on the expiry edge loses to the set
    d0 = 8'hA; do_reset(); en = 2'b01; step();
    repeat (31) step();
    irq_clr = 2'b01; step(); irq_clr = 2'b00;
    chk("t5_set_wins", 32'(irq[0]), 1);

    // 6: rst mid-EXPIRED, then disable mid-RUN
    repeat (4) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_rst_all", 32'({irq, early_err, bite, interrupt_top}), 0);
    en = 2'b01; step();
    d0 = 8'h5; step();
    chk("t6_early", 32'(early_err[0]), 1);
    repeat (10) step();
    en = 2'b00; repeat (50) step();
    chk("t6_dis_no_irq", 32'(irq[0]), 0);
    chk("t6_dis_keep_err", 32'(early_err[0]), 1);

    // 7: random traffic on both channels
    begin
      int kp0, kp1;
      do_reset(); en = 2'b11;
      kp0 = 3; kp1 = 20;
      for (int i = 0; i < 4000; i++) begin
        if (i % 200 == 0) begin
          kp0 = $urandom_range(0, 3) == 0 ? 1000 : $urandom_range(2, 25);
          kp1 = $urandom_range(0, 3) == 0 ? 1000 : $urandom_range(2, 25);
        end
        rst = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 99) == 0) en[0] = ~en[0];
        if ($urandom_range(0, 99) == 0) en[1] = ~en[1];
        if ($urandom_range(0, kp0 - 1) == 0) d0 = 8'($urandom);
        if ($urandom_range(0, kp1 - 1) == 0) d1 = 8'($urandom);
        irq_clr = 2'($urandom_range(0, 15) == 0 ? $urandom_range(1, 3) : 0);
        step();
      end
      rst = 1'b0; irq_clr = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
